// File: rtl/vpp_ts_pkg.sv
// Shared types and default timing constants for the VPP test-pin switch sequencer.
package vpp_ts_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONNECT,
        CHECK,
        ACTIVE,
        BREAK,
        DISCH
    } vpp_ts_state_e;

    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_TMO_CYC    = 64;
    localparam int DEF_DISCH_CYC  = 8;
    localparam int DEF_CW         = 8;

endpackage

// File: rtl/vpp_ts_sync2.sv
// Multi-flop synchronizer for the asynchronous level-sense comparator; all stages reset to 0.
module vpp_ts_sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge clk_i) begin
                if (srst_i) sync_q[gi] <= 1'b0;
                else        sync_q[gi] <= d_i;
            end
        end else begin : g_rest
            always_ff @(posedge clk_i) begin
                if (srst_i) sync_q[gi] <= 1'b0;
                else        sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/vpp_ts_seq.sv
// Sequencer that enables, verifies and discharges the VPP test-pin path and
// acknowledges the controller over a four-phase REQ/ACK handshake.
module vpp_ts_seq
    import vpp_ts_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TMO_CYC    = DEF_TMO_CYC,
    parameter int DISCH_CYC  = DEF_DISCH_CYC,
    parameter int CW         = DEF_CW
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ,
    input  logic SENSE,
    output logic ACK,
    output logic VPPTSEN,
    output logic VPPTSDIS,
    output logic BUSY,
    output logic ERR
);

    // The shared down-counter is loaded with N-1 on state entry so the state lasts N cycles.
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_LD    = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] DISCH_LD  = CW'(DISCH_CYC - 1);

    vpp_ts_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic          ack_q;
    logic          en_q;
    logic          dis_q;
    logic          busy_q;
    logic          err_q;
    logic          sense_s;

    vpp_ts_sync2 #(.STAGES(2)) u_sense_sync (
        .clk_i  (CLK),
        .srst_i (RST),
        .d_i    (SENSE),
        .q_o    (sense_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            dis_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (REQ) begin
                        state_q <= CONNECT;
                        cnt_q   <= SETTLE_LD;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                CONNECT: begin
                    if (!REQ) begin
                        state_q <= BREAK;
                        en_q    <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= CHECK;
                        cnt_q   <= TMO_LD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CHECK: begin
                    if (!REQ) begin
                        state_q <= BREAK;
                        en_q    <= 1'b0;
                    end else if (sense_s) begin
                        state_q <= ACTIVE;
                        ack_q   <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= BREAK;
                        en_q    <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACTIVE: begin
                    // A sagging SENSE here is deliberately not acted upon.
                    if (!REQ) begin
                        state_q <= BREAK;
                        en_q    <= 1'b0;
                    end
                end
                BREAK: begin
                    state_q <= DISCH;
                    cnt_q   <= DISCH_LD;
                    dis_q   <= 1'b1;
                end
                DISCH: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        dis_q   <= 1'b0;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ack_q   <= 1'b0;
                    en_q    <= 1'b0;
                    dis_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ACK      = ack_q;
    assign VPPTSEN  = en_q;
    assign VPPTSDIS = dis_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_vpp_ts_seq.sv
// Directed bench for vpp_ts_seq with default timing (settle 16, timeout 64, discharge 8).
module tb_vpp_ts_seq;

    logic CLK = 1'b0;
    logic RST;
    logic REQ;
    logic SENSE;
    logic ACK;
    logic VPPTSEN;
    logic VPPTSDIS;
    logic BUSY;
    logic ERR;

    int n_cmp = 0;
    int n_bad = 0;

    logic ack_prev = 1'b0;
    logic req_prev = 1'b0;

    vpp_ts_seq dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .SENSE    (SENSE),
        .ACK      (ACK),
        .VPPTSEN  (VPPTSEN),
        .VPPTSDIS (VPPTSDIS),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Continuous invariants, evaluated mid-cycle.
    always @(negedge CLK) begin
        n_cmp++;
        assert (!(VPPTSEN === 1'b1 && VPPTSDIS === 1'b1))
        else begin
            n_bad++;
            $error("FAIL en_dis_overlap: observed %b%b expected not 11 at %0t", VPPTSEN, VPPTSDIS, $time);
        end
        if (ACK === 1'b1 && ack_prev === 1'b0) begin
            n_cmp++;
            assert (req_prev === 1'b1)
            else begin
                n_bad++;
                $error("FAIL ack_without_req: observed REQ %b expected 1 at %0t", req_prev, $time);
            end
        end
        ack_prev = ACK;
        req_prev = REQ;
    end

    initial begin
        RST   = 1'b1;
        REQ   = 1'b0;
        SENSE = 1'b1;
        step(3);
        check("rst_ack",  ACK,      1'b0);
        check("rst_en",   VPPTSEN,  1'b0);
        check("rst_dis",  VPPTSDIS, 1'b0);
        check("rst_busy", BUSY,     1'b0);
        check("rst_err",  ERR,      1'b0);
        RST = 1'b0;
        step(3);
        $display("reset: outputs checked low");

        // Nominal: REQ in cycle 0, EN at 1, ACK at 18, release, discharge.
        REQ = 1'b1;
        step(1);
        check("nom_en_c1",   VPPTSEN, 1'b1);
        check("nom_busy_c1", BUSY,    1'b1);
        check("nom_ack_c1",  ACK,     1'b0);
        step(16);
        check("nom_ack_c17", ACK,     1'b0);
        check("nom_en_c17",  VPPTSEN, 1'b1);
        step(1);
        check("nom_ack_c18", ACK,     1'b1);
        REQ = 1'b0;
        step(1);
        check("nom_break_en",   VPPTSEN,  1'b0);
        check("nom_break_dis",  VPPTSDIS, 1'b0);
        check("nom_break_ack",  ACK,      1'b1);
        check("nom_break_busy", BUSY,     1'b1);
        step(1);
        check("nom_disch_first", VPPTSDIS, 1'b1);
        step(7);
        check("nom_disch_last",  VPPTSDIS, 1'b1);
        check("nom_disch_ack",   ACK,      1'b1);
        step(1);
        check("nom_idle_dis",  VPPTSDIS, 1'b0);
        check("nom_idle_ack",  ACK,      1'b0);
        check("nom_idle_busy", BUSY,     1'b0);
        $display("nominal: connect/ack/release sequence checked");

        // Timeout: SENSE held low.
        SENSE = 1'b0;
        step(3);
        REQ = 1'b1;
        step(80);
        check("tmo_en_c80",  VPPTSEN, 1'b1);
        check("tmo_err_c80", ERR,     1'b0);
        step(1);
        check("tmo_err_c81",  ERR,     1'b1);
        check("tmo_en_c81",   VPPTSEN, 1'b0);
        check("tmo_ack_c81",  ACK,     1'b0);
        check("tmo_busy_c81", BUSY,    1'b1);
        step(4);
        REQ = 1'b0;
        step(4);
        check("tmo_busy_c89", BUSY,     1'b1);
        check("tmo_dis_c89",  VPPTSDIS, 1'b1);
        step(1);
        check("tmo_busy_c90", BUSY,     1'b0);
        check("tmo_err_c90",  ERR,      1'b1);
        check("tmo_dis_c90",  VPPTSDIS, 1'b0);
        step(3);
        check("tmo_err_sticky", ERR, 1'b1);
        $display("timeout: err raised, busy dropped, err sticky");

        // Abort: REQ dropped in CONNECT cycle 5.
        REQ = 1'b1;
        step(1);
        check("abt_err_clr", ERR,     1'b0);
        check("abt_en_c1",   VPPTSEN, 1'b1);
        step(4);
        REQ = 1'b0;
        step(1);
        check("abt_en_c6",   VPPTSEN,  1'b0);
        check("abt_dis_c6",  VPPTSDIS, 1'b0);
        check("abt_busy_c6", BUSY,     1'b1);
        step(1);
        check("abt_dis_c7",  VPPTSDIS, 1'b1);
        step(7);
        check("abt_busy_c14", BUSY, 1'b1);
        step(1);
        check("abt_busy_c15", BUSY, 1'b0);
        check("abt_ack_c15",  ACK,  1'b0);
        check("abt_err_c15",  ERR,  1'b0);
        $display("abort: connect aborted without ack or err");

        // Reset in ACTIVE, then a full sequence from IDLE.
        SENSE = 1'b1;
        step(3);
        REQ = 1'b1;
        step(18);
        check("rsa_ack_c18", ACK, 1'b1);
        step(5);
        RST = 1'b1;
        step(1);
        check("rsa_en",   VPPTSEN,  1'b0);
        check("rsa_ack",  ACK,      1'b0);
        check("rsa_busy", BUSY,     1'b0);
        check("rsa_dis",  VPPTSDIS, 1'b0);
        RST = 1'b0;
        step(1);
        check("rsa_en_c1",   VPPTSEN, 1'b1);
        step(16);
        check("rsa_ack_c17", ACK, 1'b0);
        step(1);
        check("rsa_ack_c18b", ACK, 1'b1);
        REQ = 1'b0;
        step(10);
        check("rsa_busy_end", BUSY, 1'b0);
        check("rsa_ack_end",  ACK,  1'b0);
        $display("reset-in-active: outputs cleared and sequence rerun");

        // Late SENSE: rises 10 cycles into CHECK.
        SENSE = 1'b0;
        step(3);
        REQ = 1'b1;
        step(17);
        check("late_ack_c17", ACK, 1'b0);
        step(10);
        SENSE = 1'b1;
        step(2);
        check("late_ack_2e", ACK, 1'b0);
        step(1);
        check("late_ack_3e", ACK, 1'b1);
        check("late_err",    ERR, 1'b0);
        REQ = 1'b0;
        step(10);
        check("late_busy_end", BUSY, 1'b0);
        $display("late-sense: ack three edges after sense rise");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
